// File: rtl/linebuf_sched_if.sv
// Signal bundle between the sync/address front end, the line-buffer BRAMs and the
// median core. The front end is the master; linebuf_sched is the slave.
interface linebuf_sched_if #(
  parameter int ADDR_W = 11,
  parameter int ROW_W  = 11
);
  logic              vsync;
  logic              hsync;
  logic              de;
  logic [ADDR_W-1:0] width;
  logic [2:0]        wr_en;
  logic [ADDR_W-1:0] col;
  logic [1:0]        sel_top;
  logic [1:0]        sel_mid;
  logic [ROW_W-1:0]  row;
  logic              win_valid;
  logic              overrun;

  modport master (
    output vsync, hsync, de, width,
    input  wr_en, col, sel_top, sel_mid, row, win_valid, overrun
  );

  modport slave (
    input  vsync, hsync, de, width,
    output wr_en, col, sel_top, sel_mid, row, win_valid, overrun
  );
endinterface

// File: rtl/linebuf_sched.sv
// Line-buffer scheduler for the 3x3 median window: rotates the write buffer per line,
// tracks which buffers hold lines N-1/N-2 and flags when a full window is available.
module linebuf_sched #(
  parameter int ADDR_W = 11,
  parameter int ROW_W  = 11
) (
  input logic            clk,
  input logic            rst,
  linebuf_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              hsync_d_r, vsync_d_r;
  logic              hs_rise_s, vs_rise_s;
  logic [1:0]        wr_sel_r, wr_sel_s;
  logic [1:0]        sel_mid_r, sel_mid_s;
  logic [1:0]        sel_top_r, sel_top_s;
  logic [ADDR_W-1:0] col_cnt_r, col_cnt_s;
  logic [ADDR_W-1:0] col_r, col_s;
  logic [ROW_W-1:0]  row_r, row_s;
  logic [ROW_W-1:0]  row_inc_s;
  logic [2:0]        wr_en_r, wr_en_s;
  logic              win_valid_r, win_valid_s;
  logic              overrun_r, overrun_s;
  logic              pix_ok_s;

  function automatic logic [2:0] sel_to_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    case (sel)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic [1:0] sel_rotate(input logic [1:0] sel);
    logic [1:0] nxt;
    case (sel)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  assign hs_rise_s = bus.hsync & ~hsync_d_r;
  assign vs_rise_s = bus.vsync & ~vsync_d_r;
  // width==0 means the line length is unknown, so every pixel is accepted.
  assign pix_ok_s  = (bus.width == {ADDR_W{1'b0}}) || (col_cnt_r < bus.width);
  assign row_inc_s = (row_r == {ROW_W{1'b1}}) ? row_r : (row_r + ROW_W'(1));

  // Next-state and next-output decode; vsync edge outranks hsync edge outranks de
  always_comb begin
    state_s     = state_r;
    wr_sel_s    = wr_sel_r;
    sel_mid_s   = sel_mid_r;
    sel_top_s   = sel_top_r;
    col_cnt_s   = col_cnt_r;
    col_s       = col_r;
    row_s       = row_r;
    overrun_s   = overrun_r;
    wr_en_s     = 3'b000;
    win_valid_s = 1'b0;

    if (vs_rise_s) begin
      state_s   = ST_FILL;
      row_s     = {ROW_W{1'b0}};
      col_cnt_s = {ADDR_W{1'b0}};
      col_s     = {ADDR_W{1'b0}};
      wr_sel_s  = 2'd0;
      sel_mid_s = 2'd2;
      sel_top_s = 2'd1;
      overrun_s = 1'b0;
    end else if (hs_rise_s) begin
      if (state_r != ST_IDLE) begin
        col_cnt_s = {ADDR_W{1'b0}};
        col_s     = {ADDR_W{1'b0}};
        row_s     = row_inc_s;
        wr_sel_s  = sel_rotate(wr_sel_r);
        sel_mid_s = wr_sel_r;
        sel_top_s = sel_mid_r;
        if ((state_r == ST_FILL) && (row_inc_s == ROW_W'(2))) begin
          state_s = ST_RUN;
        end else begin
          state_s = state_r;
        end
      end else begin
        state_s = ST_IDLE;
      end
    end else if (bus.de) begin
      if (state_r != ST_IDLE) begin
        if (pix_ok_s) begin
          wr_en_s     = sel_to_onehot(wr_sel_r);
          col_s       = col_cnt_r;
          col_cnt_s   = col_cnt_r + ADDR_W'(1);
          win_valid_s = (state_r == ST_RUN) && (col_cnt_r >= ADDR_W'(2));
        end else begin
          overrun_s = 1'b1;
        end
      end else begin
        wr_en_s = 3'b000;
      end
    end else begin
      wr_en_s = 3'b000;
    end
  end

  // Edge-detect history and all scheduler state/outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      hsync_d_r   <= 1'b0;
      vsync_d_r   <= 1'b0;
      wr_sel_r    <= 2'd0;
      sel_mid_r   <= 2'd2;
      sel_top_r   <= 2'd1;
      col_cnt_r   <= {ADDR_W{1'b0}};
      col_r       <= {ADDR_W{1'b0}};
      row_r       <= {ROW_W{1'b0}};
      wr_en_r     <= 3'b000;
      win_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      hsync_d_r   <= bus.hsync;
      vsync_d_r   <= bus.vsync;
      wr_sel_r    <= wr_sel_s;
      sel_mid_r   <= sel_mid_s;
      sel_top_r   <= sel_top_s;
      col_cnt_r   <= col_cnt_s;
      col_r       <= col_s;
      row_r       <= row_s;
      wr_en_r     <= wr_en_s;
      win_valid_r <= win_valid_s;
      overrun_r   <= overrun_s;
    end
  end

  assign bus.wr_en     = wr_en_r;
  assign bus.col       = col_r;
  assign bus.sel_top   = sel_top_r;
  assign bus.sel_mid   = sel_mid_r;
  assign bus.row       = row_r;
  assign bus.win_valid = win_valid_r;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_linebuf_sched.sv
// Directed bench for linebuf_sched: fill/rotation, buffer wrap, overrun, same-cycle
// sync events and asynchronous reset in the middle of a frame.
module tb_linebuf_sched;
  localparam int ADDR_W = 11;
  localparam int ROW_W  = 11;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  linebuf_sched_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) bus ();

  linebuf_sched #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic h, input logic d);
    bus.vsync = v;
    bus.hsync = h;
    bus.de    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic hs_pulse(input int exp_row);
    step(1'b0, 1'b1, 1'b0);
    check_val("hs_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("hs_row", 32'(bus.row), 32'(exp_row));
  endtask

  task automatic vs_pulse();
    step(1'b1, 1'b0, 1'b0);
    check_val("vs_row", 32'(bus.row), 32'd0);
    check_val("vs_overrun", 32'(bus.overrun), 32'd0);
    check_val("vs_sel_mid", 32'(bus.sel_mid), 32'd2);
    check_val("vs_sel_top", 32'(bus.sel_top), 32'd1);
  endtask

  task automatic send_pixels(input int n, input logic [2:0] exp_we, input logic [1:0] exp_mid,
                             input logic [1:0] exp_top, input bit run, output int wins);
    int w;
    w    = int'(bus.width);
    wins = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (w == 0 || i < w) begin
        check_val("px_wr_en", 32'(bus.wr_en), 32'(exp_we));
        check_val("px_col", 32'(bus.col), 32'(i));
        check_val("px_win", 32'(bus.win_valid), 32'(run && i >= 2));
        check_val("px_overrun0", 32'(bus.overrun), 32'd0);
      end else begin
        check_val("ovr_wr_en", 32'(bus.wr_en), 32'd0);
        check_val("ovr_flag", 32'(bus.overrun), 32'd1);
        check_val("ovr_win", 32'(bus.win_valid), 32'd0);
      end
      check_val("px_sel_mid", 32'(bus.sel_mid), 32'(exp_mid));
      check_val("px_sel_top", 32'(bus.sel_top), 32'(exp_top));
      check_val("distinct", 32'((bus.sel_mid != bus.sel_top) && (bus.sel_mid < 2'd3) &&
                                (bus.sel_top < 2'd3)), 32'd1);
      wins += int'(bus.win_valid);
    end
  endtask

  initial begin
    int wins;
    rst       = 1'b1;
    bus.vsync = 1'b0;
    bus.hsync = 1'b0;
    bus.de    = 1'b0;
    bus.width = 11'd8;
    #22;
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check_val("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("rst_col", 32'(bus.col), 32'd0);
    check_val("rst_row", 32'(bus.row), 32'd0);
    check_val("rst_sel_mid", 32'(bus.sel_mid), 32'd2);
    check_val("rst_sel_top", 32'(bus.sel_top), 32'd1);
    check_val("rst_win", 32'(bus.win_valid), 32'd0);
    check_val("rst_overrun", 32'(bus.overrun), 32'd0);

    // de and hsync without vsync must not leave IDLE
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1);
      check_val("idle_wr_en", 32'(bus.wr_en), 32'd0);
      check_val("idle_win", 32'(bus.win_valid), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0);
    check_val("idle_hs_row", 32'(bus.row), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check_val("idle_de_wr_en", 32'(bus.wr_en), 32'd0);

    // Fill, rotation and buffer wrap over five lines
    vs_pulse();
    send_pixels(8, 3'b001, 2'd2, 2'd1, 1'b0, wins);
    check_val("line0_wins", 32'(wins), 32'd0);
    hs_pulse(1);
    send_pixels(8, 3'b010, 2'd0, 2'd2, 1'b0, wins);
    check_val("line1_wins", 32'(wins), 32'd0);
    hs_pulse(2);
    send_pixels(8, 3'b100, 2'd1, 2'd0, 1'b1, wins);
    check_val("line2_wins", 32'(wins), 32'd6);
    hs_pulse(3);
    send_pixels(8, 3'b001, 2'd2, 2'd1, 1'b1, wins);
    check_val("line3_wins", 32'(wins), 32'd6);
    hs_pulse(4);
    send_pixels(8, 3'b010, 2'd0, 2'd2, 1'b1, wins);
    hs_pulse(5);

    // Overrun: only four pixels fit, flag sticks until next vsync
    bus.width = 11'd4;
    vs_pulse();
    send_pixels(6, 3'b001, 2'd2, 2'd1, 1'b0, wins);
    check_val("ovr_last_col", 32'(bus.col), 32'd3);
    hs_pulse(1);
    check_val("ovr_sticky", 32'(bus.overrun), 32'd1);
    vs_pulse();

    // vsync + hsync + de in one cycle: restart frame, drop the pixel
    bus.width = 11'd8;
    send_pixels(2, 3'b001, 2'd2, 2'd1, 1'b0, wins);
    hs_pulse(1);
    send_pixels(2, 3'b010, 2'd0, 2'd2, 1'b0, wins);
    step(1'b1, 1'b1, 1'b1);
    check_val("sim_vs_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("sim_vs_row", 32'(bus.row), 32'd0);
    check_val("sim_vs_col", 32'(bus.col), 32'd0);
    check_val("sim_vs_sel_mid", 32'(bus.sel_mid), 32'd2);
    step(1'b0, 1'b0, 1'b0);
    send_pixels(3, 3'b001, 2'd2, 2'd1, 1'b0, wins);

    // hsync + de: the pixel is dropped and the column restarts
    step(1'b0, 1'b1, 1'b1);
    check_val("sim_hs_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("sim_hs_col", 32'(bus.col), 32'd0);
    check_val("sim_hs_row", 32'(bus.row), 32'd1);
    send_pixels(1, 3'b010, 2'd0, 2'd2, 1'b0, wins);

    // Asynchronous reset during line 3 of RUN
    vs_pulse();
    send_pixels(3, 3'b001, 2'd2, 2'd1, 1'b0, wins);
    hs_pulse(1);
    send_pixels(3, 3'b010, 2'd0, 2'd2, 1'b0, wins);
    hs_pulse(2);
    send_pixels(3, 3'b100, 2'd1, 2'd0, 1'b1, wins);
    hs_pulse(3);
    send_pixels(3, 3'b001, 2'd2, 2'd1, 1'b1, wins);
    rst = 1'b1;
    #2;
    check_val("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("mid_rst_col", 32'(bus.col), 32'd0);
    check_val("mid_rst_row", 32'(bus.row), 32'd0);
    check_val("mid_rst_sel_mid", 32'(bus.sel_mid), 32'd2);
    check_val("mid_rst_sel_top", 32'(bus.sel_top), 32'd1);
    check_val("mid_rst_win", 32'(bus.win_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      check_val("post_rst_wr_en", 32'(bus.wr_en), 32'd0);
      step(1'b0, 1'b1, 1'b0);
      check_val("post_rst_row", 32'(bus.row), 32'd0);
    end
    vs_pulse();
    send_pixels(3, 3'b001, 2'd2, 2'd1, 1'b0, wins);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/linebuf_sched.md
Name: linebuf_sched

Overview:
- Sequences the three line buffers feeding the 3x3 median window: chooses which buffer receives the incoming line, which two supply the rows above, and when a full 3x3 window is valid.
- Sits between the sync/address front end (hsync, vsync, measured `width`) and the line-buffer BRAMs plus the median core.
- All outputs are registered.

Parameters:
- ADDR_W, 11, width of column counter, `width` input and `col` output.
- ROW_W, 11, width of row counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- vsync  in  1  frame sync; rising edge starts a frame
- hsync  in  1  line sync; rising edge ends the current line
- de  in  1  pixel valid for the current line
- width  in  ADDR_W  active pixels per line, from the address controller; 0 = unknown
- wr_en  out  3  one-hot write enable to line buffers 0..2
- col  out  ADDR_W  write/read column address for all buffers
- sel_top  out  2  buffer index holding line N-2
- sel_mid  out  2  buffer index holding line N-1
- row  out  ROW_W  index of the line currently being written
- win_valid  out  1  3x3 window at (row-1, col-1) is valid this cycle
- overrun  out  1  sticky: de seen past `width` in this frame

Behaviour:
- Reset (async, active-high) forces these values:
  - state=IDLE, wr_sel=0, wr_en=0, col=0, row=0
  - sel_mid=2, sel_top=1, win_valid=0, overrun=0
  - hsync_d=0, vsync_d=0
- Edge detect: hs_rise = hsync & ~hsync_d and vs_rise = vsync & ~vsync_d. Both are registered every cycle.
- States:
  - IDLE: wait for vs_rise, then go to FILL.
  - FILL: row < 2. win_valid is held at 0.
  - RUN: row >= 2.
- Any state on vs_rise → FILL, with:
  - row=0, col=0, wr_sel=0, sel_mid=2, sel_top=1, overrun=0.
  - vs_rise has priority over a same-cycle hs_rise and de.
- hs_rise (no vs_rise):
  - col←0, row←row+1 (saturates at all-ones).
  - Rotate wr_sel 0→1→2→0.
  - sel_mid←old wr_sel; sel_top←old sel_mid.
  - In FILL, when row becomes 2 → RUN.
  - An hs_rise in IDLE is ignored.
- de with no edge, in FILL or RUN:
  - If width==0 or col < width: wr_en = one-hot(wr_sel) on the next cycle, col presented with it, then col←col+1.
  - Otherwise: wr_en=0 and overrun←1 (sticky until the next vs_rise or reset).
  - col wraps at 2^ADDR_W only when width==0.
- de coinciding with hs_rise or vs_rise is dropped: wr_en=0 and col is not advanced.
- de in IDLE produces no write.
- Latency: wr_en, col and win_valid appear 1 cycle after the sampled de.
- win_valid=1 exactly when all of the following hold: state==RUN, the pixel is accepted (wr_en nonzero), and col >= 2.
  - The first valid window of a line is therefore its third pixel.
- Invariants:
  - wr_sel, sel_mid and sel_top are always distinct.
  - Each lies in 0..2; value 3 never appears.
- Reset mid-frame: state returns to IDLE. No writes occur until the next vs_rise, even if hsync and de keep toggling.

Test Plan:
- Reset/idle: rst=1 for 22 ns, then de pulses with no vsync → wr_en=0, win_valid=0, state IDLE, row=0.
- Fill and rotation:
  - Stimulus: vs_rise, then 3 lines of 8 de pixels separated by hs_rise, with width=8.
  - Line 0: wr_en=001.
  - Line 1: wr_en=010, sel_mid=0.
  - Line 2: wr_en=100, sel_mid=1, sel_top=0.
  - win_valid is 0 on lines 0–1.
  - On line 2, win_valid is 1 for col=2..7, i.e. 6 pulses.
- Wrap of buffer selection:
  - Stimulus: 5 lines.
  - Line 3: wr_en=001, sel_mid=2, sel_top=1.
  - Line 4: wr_en=010.
  - The three selects are distinct every cycle.
- Overrun: width=4 and 6 de pixels in one line → 4 writes (col 0..3), overrun=1 from the 5th pixel; the next vs_rise clears it.
- Simultaneous events:
  - vs_rise with hs_rise and de in the same cycle → row=0, wr_sel=0, no write.
  - hs_rise with de → that pixel is dropped and col=0.
- Reset mid-frame: rst pulse during line 3 of RUN → all outputs return to reset values immediately (async), and no writes occur until the next vsync.
